// File: rtl/inst_sram_axi_resp_pkg.sv
// Shared constants for the instruction-side SRAM-to-AXI read responder.
// Includes the AXI encodings, the inst-side ID and the AR FSM state codes.
package inst_sram_axi_resp_pkg;

    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [2:0] AxiSize4B    = 3'd2;
    localparam logic [1:0] AxiRespOkay  = 2'b00;
    localparam logic [3:0] InstArid     = 4'h0;

    localparam logic [0:0] ArIdle = 1'b0;
    localparam logic [0:0] ArWait = 1'b1;

    // An R beat is bad if it carries a non-OKAY status or a foreign ID.
    function automatic logic r_beat_bad(input logic [3:0] id, input logic [3:0] exp_id,
                                        input logic [1:0] resp);
        return (resp != AxiRespOkay) || (id != exp_id);
    endfunction

endpackage

// File: rtl/inst_sram_axi_resp_ar_reg.sv
// AR channel holding register: captures an address on load and presents it
// with arvalid until arready; idle tells the owner a new load is allowed.
module inst_sram_axi_resp_ar_reg
    import inst_sram_axi_resp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic        arvalid,
    output logic        idle
);

    logic [0:0]  state_q, state_d;
    logic [31:0] addr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ArIdle:  if (load) state_d = ArWait;
            ArWait:  if (arready) state_d = ArIdle;
            default: state_d = ArIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ArIdle;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load && (state_q == ArIdle)) addr_q <= load_addr;
        end
    end

    assign araddr  = addr_q;
    assign arvalid = (state_q == ArWait);
    assign idle    = (state_q == ArIdle);

endmodule

// File: rtl/inst_sram_axi_resp.sv
// Instruction-side SRAM-like responder: turns fetch requests into single-beat
// AXI reads and returns the words in order with one-cycle data_ok pulses.
module inst_sram_axi_resp
    import inst_sram_axi_resp_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = InstArid
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_err
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;
    logic            ar_idle;
    logic            data_ok_q;
    logic [31:0]     rdata_q;
    logic            bus_err_q;
    logic            unused_inputs;

    assign unused_inputs = ^{inst_sram_wdata, rlast};

    // Depends only on local state, never on en or any AXI input.
    assign addr_ok = ar_idle && (cnt_q < CntW'(MAX_OUTSTANDING));
    assign accept  = inst_sram_en && addr_ok;

    inst_sram_axi_resp_ar_reg u_ar_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_addr (inst_sram_addr),
        .arready   (arready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .idle      (ar_idle)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !data_ok_q) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!accept && data_ok_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            data_ok_q <= rvalid;
            if (rvalid) rdata_q <= rdata;
            if ((rvalid && r_beat_bad(rid, ARID_VAL, rresp)) ||
                (accept && (inst_sram_we != '0))) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign data_ok         = data_ok_q;
    assign inst_sram_rdata = rdata_q;
    assign bus_err         = bus_err_q;
    assign rready          = 1'b1;
    assign arid            = ARID_VAL;
    assign arlen           = 8'd0;
    assign arsize          = AxiSize4B;
    assign arburst         = AxiBurstIncr;

endmodule

// File: tb/tb_inst_sram_axi_resp.sv
// Directed bench for inst_sram_axi_resp: stimulus pushes the expected word per
// accepted fetch, a negedge monitor pops and compares on every data_ok.
module tb_inst_sram_axi_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bus_err;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    inst_sram_axi_resp dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .addr_ok         (addr_ok),
        .data_ok         (data_ok),
        .inst_sram_rdata (inst_sram_rdata),
        .arid            (arid),
        .araddr          (araddr),
        .arlen           (arlen),
        .arsize          (arsize),
        .arburst         (arburst),
        .arvalid         (arvalid),
        .arready         (arready),
        .rid             (rid),
        .rdata           (rdata),
        .rresp           (rresp),
        .rlast           (rlast),
        .rvalid          (rvalid),
        .rready          (rready),
        .bus_err         (bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Scoreboard monitor: every data_ok must match the oldest outstanding fetch.
    always @(negedge clk) begin
        if (data_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL data_ok_unexpected: got rdata 0x%08h, want no pulse",
                         inst_sram_rdata);
            end else begin
                check("rdata_order", inst_sram_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] we_v, input logic [31:0] d);
        int n = 0;
        inst_sram_en   = 1'b1;
        inst_sram_addr = a;
        inst_sram_we   = we_v;
        while (!addr_ok && n < 8) begin
            step();
            n++;
        end
        check("addr_ok_wait", 32'(addr_ok), 32'd1);
        if (addr_ok) exp_q.push_back(d);
        step();
        inst_sram_en   = 1'b0;
        inst_sram_we   = 4'h0;
        inst_sram_addr = 32'hdeadbeef;
    endtask

    task automatic ar_hs(input logic [31:0] a);
        int n = 0;
        while (!arvalid && n < 8) begin
            step();
            n++;
        end
        check("ar_arvalid", 32'(arvalid), 32'd1);
        check("ar_araddr", araddr, a);
        arready = 1'b1;
        step();
        arready = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp);
        rvalid = 1'b1;
        rdata  = d;
        rid    = id;
        rresp  = resp;
        step();
        rvalid = 1'b0;
        rdata  = 32'h0;
        rid    = 4'h0;
        rresp  = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        inst_sram_en = 1'b0;
        inst_sram_we = 4'h0;
        inst_sram_addr = 32'h0;
        inst_sram_wdata = 32'h0;
        arready = 1'b0;
        rid = 4'h0;
        rdata = 32'h0;
        rresp = 2'b00;
        rlast = 1'b1;
        rvalid = 1'b0;
        step();
        step();
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_rdata", inst_sram_rdata, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_rready", 32'(rready), 32'd1);
        check("rst_addr_ok", 32'(addr_ok), 32'd1);
        check("rst_ar_const", {arid, arlen, arsize, arburst}, {4'h0, 8'h00, 3'd2, 2'b01});
        reset = 1'b0;
        step();

        // Single fetch with minimum latency.
        check("t1_addr_ok_c0", 32'(addr_ok), 32'd1);
        issue(32'h1c000000, 4'h0, 32'h02800000);
        check("t1_arvalid_c1", 32'(arvalid), 32'd1);
        check("t1_araddr_c1", araddr, 32'h1c000000);
        ar_hs(32'h1c000000);
        check("t1_arvalid_c2", 32'(arvalid), 32'd0);
        r_beat(32'h02800000, 4'h0, 2'b00);
        check("t1_data_ok_c3", 32'(data_ok), 32'd1);
        check("t1_rdata_c3", inst_sram_rdata, 32'h02800000);
        step();
        check("t1_data_ok_c4", 32'(data_ok), 32'd0);
        check("t1_cnt_c4", 32'(dut.cnt_q), 32'd0);

        // AR backpressure: address held, next request only after the handshake.
        issue(32'h1c000004, 4'h0, 32'haaaa0001);
        inst_sram_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_sram_addr = 32'h0bad0000 + 32'(i);
            check("t2_arvalid_hold", 32'(arvalid), 32'd1);
            check("t2_araddr_hold", araddr, 32'h1c000004);
            check("t2_addr_ok_hold", 32'(addr_ok), 32'd0);
            step();
        end
        inst_sram_addr = 32'h1c000008;
        ar_hs(32'h1c000004);
        check("t2_addr_ok_after_hs", 32'(addr_ok), 32'd1);
        issue(32'h1c000008, 4'h0, 32'haaaa0002);
        r_beat(32'haaaa0001, 4'h0, 2'b00);
        ar_hs(32'h1c000008);
        r_beat(32'haaaa0002, 4'h0, 2'b00);
        step();
        check("t2_cnt_end", 32'(dut.cnt_q), 32'd0);

        // Outstanding limit of two.
        issue(32'h1c000010, 4'h0, 32'h11111111);
        ar_hs(32'h1c000010);
        issue(32'h1c000014, 4'h0, 32'h22222222);
        ar_hs(32'h1c000014);
        check("t3_cnt_full", 32'(dut.cnt_q), 32'd2);
        check("t3_addr_ok_full", 32'(addr_ok), 32'd0);
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'h1c000018;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t3_addr_ok_blocked", 32'(addr_ok), 32'd0);
            check("t3_no_ar", 32'(arvalid), 32'd0);
        end
        inst_sram_en = 1'b0;
        r_beat(32'h11111111, 4'h0, 2'b00);
        check("t3_addr_ok_dok_cycle", 32'(addr_ok), 32'd0);
        step();
        check("t3_addr_ok_back", 32'(addr_ok), 32'd1);
        check("t3_cnt_one", 32'(dut.cnt_q), 32'd1);
        r_beat(32'h22222222, 4'h0, 2'b00);
        step();
        check("t3_cnt_end", 32'(dut.cnt_q), 32'd0);

        // Acceptance and data_ok in the same cycle at cnt=1.
        issue(32'h1c000020, 4'h0, 32'h33333333);
        ar_hs(32'h1c000020);
        r_beat(32'h33333333, 4'h0, 2'b00);
        check("t4_data_ok", 32'(data_ok), 32'd1);
        issue(32'h1c000024, 4'h0, 32'h44444444);
        check("t4_cnt_same", 32'(dut.cnt_q), 32'd1);
        ar_hs(32'h1c000024);
        r_beat(32'h44444444, 4'h0, 2'b00);
        step();
        check("t4_cnt_end", 32'(dut.cnt_q), 32'd0);

        // Error responses still complete; bus_err is sticky until reset.
        issue(32'h1c000030, 4'h0, 32'h55555555);
        ar_hs(32'h1c000030);
        check("t5_bus_err_pre", 32'(bus_err), 32'd0);
        r_beat(32'h55555555, 4'h0, 2'b10);
        check("t5_bus_err_rresp", 32'(bus_err), 32'd1);
        step();
        step();
        step();
        check("t5_bus_err_sticky", 32'(bus_err), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        check("t5_bus_err_cleared", 32'(bus_err), 32'd0);
        issue(32'h1c000034, 4'h0, 32'h66666666);
        ar_hs(32'h1c000034);
        check("t5_bus_err_pre_rid", 32'(bus_err), 32'd0);
        r_beat(32'h66666666, 4'h3, 2'b00);
        check("t5_bus_err_rid", 32'(bus_err), 32'd1);
        step();
        step();

        // Reset with two outstanding and arvalid held.
        issue(32'h1c000040, 4'h0, 32'h77777777);
        ar_hs(32'h1c000040);
        issue(32'h1c000044, 4'h0, 32'h88888888);
        check("t6_arvalid_pre", 32'(arvalid), 32'd1);
        check("t6_cnt_pre", 32'(dut.cnt_q), 32'd2);
        reset = 1'b1;
        exp_q.delete();
        step();
        check("t6_arvalid_rst", 32'(arvalid), 32'd0);
        check("t6_data_ok_rst", 32'(data_ok), 32'd0);
        check("t6_cnt_rst", 32'(dut.cnt_q), 32'd0);
        check("t6_addr_ok_rst", 32'(addr_ok), 32'd1);
        check("t6_bus_err_rst", 32'(bus_err), 32'd0);
        reset = 1'b0;
        issue(32'h1c000000, 4'h0, 32'h02800000);
        ar_hs(32'h1c000000);
        r_beat(32'h02800000, 4'h0, 2'b00);
        check("t6_data_ok_fresh", 32'(data_ok), 32'd1);
        step();
        check("t6_bus_err_fresh", 32'(bus_err), 32'd0);

        // Write strobe on a fetch: flagged, still served as a read.
        issue(32'h1c000048, 4'hf, 32'h99999999);
        check("t7_bus_err_we", 32'(bus_err), 32'd1);
        ar_hs(32'h1c000048);
        r_beat(32'h99999999, 4'h0, 2'b00);
        check("t7_data_ok_we", 32'(data_ok), 32'd1);
        step();
        step();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/inst_sram_axi_resp.md
Name: inst_sram_axi_resp

Overview:
- Responder end of the instruction-side SRAM-like request interface that the pre-IF stage drives (en / addr / addr_ok / data_ok / rdata).
- Accepts fetch requests, issues single-beat AXI read bursts to memory, and returns instruction words in order with data_ok pulses.
- Sits between the fetch front end and the top-level AXI read port.

Parameters:
- MAX_OUTSTANDING, 2: maximum number of accepted requests whose data_ok has not yet been returned.
- ARID_VAL, 4'h0: AXI ID driven on arid and expected on rid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_sram_en  in  1  request valid; held until addr_ok
- inst_sram_we  in  4  write strobe; must be 0 (read-only side)
- inst_sram_addr  in  32  word-aligned fetch address
- inst_sram_wdata  in  32  unused
- addr_ok  out  1  request accepted this cycle (when inst_sram_en=1)
- data_ok  out  1  one-cycle pulse: inst_sram_rdata valid
- inst_sram_rdata  out  32  returned instruction word
- arid  out  4  = ARID_VAL
- araddr  out  32  read address
- arlen  out  8  = 0
- arsize  out  3  = 3'd2
- arburst  out  2  = 2'b01
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  response ID
- rdata  in  32  response data
- rresp  in  2  response status
- rlast  in  1  ignored (single beat)
- rvalid  in  1  R valid
- rready  out  1  R ready
- bus_err  out  1  sticky: rresp != 0, rid mismatch, or we != 0 seen

Behaviour:
- Reset values:
  - arvalid=0, data_ok=0, inst_sram_rdata=0, bus_err=0, rready=1.
  - Outstanding count=0; AR FSM=IDLE.
- Outstanding counter width: $clog2(MAX_OUTSTANDING+1).
  - +1 on acceptance (inst_sram_en && addr_ok).
  - −1 on a data_ok pulse.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- addr_ok is combinational: (state==IDLE) && (cnt < MAX_OUTSTANDING). It is independent of inst_sram_en and has no combinational path from AXI inputs.
- AR FSM:
  - IDLE: on acceptance, latch inst_sram_addr into araddr and go to AR_WAIT. arvalid=1 from the next cycle.
  - AR_WAIT: arvalid=1 and araddr stable until arready. On arready, go to IDLE; arvalid=0 next cycle.
  - Consequence: a new request can be accepted no earlier than the cycle after the AR handshake, so consecutive requests are at least 2 cycles apart.
- R path:
  - rready is tied 1. Space is guaranteed by the outstanding limit.
  - On rvalid: inst_sram_rdata <= rdata and data_ok <= 1 for exactly the next cycle.
  - data_ok is 0 in every other cycle.
- Ordering: single ID and in-order AXI, so data_ok order equals request acceptance order.
- Minimum latency: accept at cycle N → arvalid at N+1 → (arready N+1, rvalid N+2) → data_ok at N+3.
- Error handling:
  - Any of rresp != 2'b00, rid != ARID_VAL, or (acceptance with inst_sram_we != 0) sets bus_err, which stays set until reset.
  - The transaction still completes normally: data_ok pulses and rdata is passed through; a we != 0 request is treated as a read.
- Discarding stale fetches is the requester's job (it counts data_ok). This block never cancels or drops a response.
- Reset mid-operation:
  - All state is cleared in one cycle.
  - The AXI memory shares the same reset, so no stale R beats may arrive afterwards; a beat that does arrive is an environment error.
  - data_ok is 0 in the cycle after reset is asserted.
- inst_sram_addr may change while en=1 and addr_ok=0. Only the value present in the acceptance cycle is used.

Decomposition:
- Shared header mycpu.h gets: AXI burst/size/resp constants (`AXI_BURST_INCR, `AXI_SIZE_4B, `AXI_RESP_OKAY), and the inst-side ID value.
- No sub-module is needed; a single module with AR FSM, counter and R register suffices.
- An optional sub-module, axi_ar_reg, holds the araddr/arvalid hold-until-ready register, reusable by a future data-side responder.

Test Plan:
- Single fetch: en=1, addr=0x1c000000, arready=1, rvalid one cycle later with rdata=0x02800000.
  - Required: addr_ok at cycle 0, arvalid/araddr=0x1c000000 at cycle 1, data_ok=1 and rdata=0x02800000 at cycle 3, count back to 0.
- AR backpressure: arready=0 for 3 cycles.
  - Required: arvalid held with stable araddr, addr_ok=0 throughout, next request accepted the cycle after the handshake.
- Outstanding limit (MAX=2): two requests accepted, R withheld.
  - Required: addr_ok=0 with cnt=2; after one data_ok, addr_ok returns.
  - Responses 0x11111111 then 0x22222222 must return in that order.
- Simultaneous acceptance and data_ok at cnt=1.
  - Required: cnt stays 1, no lost or duplicated data_ok.
- Error: rresp=2'b10, then a rid=4'h3 response.
  - Required: data_ok still pulses for both; bus_err=1 and sticky until reset.
- Reset with two outstanding and arvalid=1.
  - Required: next cycle arvalid=0, data_ok=0, cnt=0, addr_ok=1; a fresh fetch of 0x1c000000 completes normally.
